gate_truth_sequencer: RTL and testbench
=======================================

Name: gate_truth_sequencer

Overview:
Self-checking controller that sequences a single N-input basic gate (XNOR, NAND, etc.) through every input combination in hardware.
- Drives the gate inputs, waits a programmable settle time, samples the gate output and compares it against a caller-supplied truth table.
- Reports per-vector mismatches and an overall pass flag.
- Sits between a test/control host and the gate primitive under test, replacing free-running testbench stimulus with a deterministic, repeatable sweep.

Parameters:
- N_IN, 2, number of gate inputs (1..4); vector count V = 2^N_IN.
- SETTLE_CYCLES, 2, clock cycles to hold each vector before sampling (0..255).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- truth_table  input  V  expected output; bit i = expected gate_out when gate_in == i; captured at start.
- gate_in  output  N_IN  registered drive to the gate inputs; bit 0 = in1, bit 1 = in2, ...
- gate_out  input  1  gate output under test.
- busy  output  1  high from the cycle after start is accepted until DONE exits.
- done  output  1  one-cycle pulse at sweep completion.
- pass  output  1  1 if no mismatch in the last completed sweep; held until the next start.
- fail_mask  output  V  bit i set if vector i mismatched; held until the next start.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, gate_in=0, busy=0, done=0, pass=0, fail_mask=0, internal idx=0, cnt=0.
  - Reset mid-sweep aborts the sweep with no done pulse.
- States: IDLE, SETTLE, SAMPLE, DONE (encoded in the package).
- IDLE, start=1: capture truth_table into tt_q, clear fail_mask, pass=0, idx=0, gate_in=0, cnt=SETTLE_CYCLES, go to SETTLE.
- SETTLE: if cnt==0, go to SAMPLE; else cnt--.
- SAMPLE: if gate_out != tt_q[idx], set fail_mask[idx]. Then:
  - idx==V-1: go to DONE.
  - otherwise: idx++, gate_in=idx+1, cnt=SETTLE_CYCLES, go to SETTLE.
- DONE: done=1 for exactly this cycle; pass = (fail_mask==0, including the final SAMPLE's update); go to IDLE.
- busy=1 in SETTLE, SAMPLE and DONE.
- Latency: done is high in the cycle starting V*(SETTLE_CYCLES+2) rising edges after the edge that samples start. For N_IN=2 and SETTLE_CYCLES=2 that is 16 edges.
- Per vector: gate_in is stable for SETTLE_CYCLES+2 cycles; gate_out is sampled on the final edge of that window.
- start while busy: ignored (no restart, no effect on tt_q).
- start held high continuously: a new sweep begins in the IDLE cycle following DONE, so back-to-back sweeps have exactly one IDLE cycle between them.
- SETTLE_CYCLES=0: SETTLE lasts one cycle, giving 2 cycles per vector.
- truth_table changes during a sweep are ignored; tt_q is used.
- idx width is N_IN bits; no wrap beyond V-1. The terminal compare uses idx==V-1.

Optional Feature:
Macro: GATE_SEQ_ERR_LOG_EN

Defined: adds two outputs.
- err_count  output  N_IN+1  number of mismatching vectors; cleared at start, incremented in SAMPLE on mismatch, saturates at V.
- first_err_idx  output  N_IN  idx of the first mismatch, captured once per sweep; 0 if none.
- Both reset to 0 and hold after DONE until the next start.

Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package gate_seq_pkg:
  - state enum typedef (IDLE, SETTLE, SAMPLE, DONE).
  - localparam for the settle counter width (8).
  - function computing V from N_IN.
- Sub-module gate_seq_settle_timer: loadable down-counter with a zero flag. Inputs: load, load value, enable. Reused for any future hold-time sequencing.
- The FSM, compare and fail logic stay in gate_truth_sequencer.

Test Plan:
- XNOR pass: N_IN=2, SETTLE_CYCLES=2, ideal XNOR model on gate_in, truth_table=4'b1001, pulse start.
  -> gate_in steps 0,1,2,3, each held 4 cycles; done 16 edges after start; pass=1; fail_mask=0000.
- Wrong table: same XNOR model, truth_table=4'b0110.
  -> fail_mask=1111, pass=0; with GATE_SEQ_ERR_LOG_EN, err_count=4, first_err_idx=0.
- Single fault: model outputs 1 for gate_in=2 only, truth_table=4'b1001.
  -> fail_mask=0100, pass=0; with the macro, err_count=1, first_err_idx=2.
- Start while busy plus table change: second start and truth_table=0000 applied at edge 5 of a sweep.
  -> ignored; results match the original table; one done pulse total.
- Reset mid-sweep: assert rst at edge 7.
  -> all outputs 0 immediately (asynchronous); no done pulse; a subsequent start runs a full clean 16-cycle sweep.
- SETTLE_CYCLES=0 with start held high.
  -> each vector lasts 2 cycles; done at edge 8; next sweep begins after one IDLE cycle.

Source files
------------

// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate truth-table sequencer.
//   - FSM state encoding (IDLE, SETTLE, SAMPLE, DONE)
//   - settle counter width
//   - v_count(): number of input vectors for an N-input gate
package gate_seq_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        E_IDLE   = 2'd0,
        E_SETTLE = 2'd1,
        E_SAMPLE = 2'd2,
        E_DONE   = 2'd3
    } state_e;

    // Flat constants of the same encoding, used by the FSM register.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'(E_IDLE);
    localparam state_t ST_SETTLE = 2'(E_SETTLE);
    localparam state_t ST_SAMPLE = 2'(E_SAMPLE);
    localparam state_t ST_DONE   = 2'(E_DONE);

    function automatic int unsigned v_count(input int unsigned n_in);
        return 32'(1) << n_in;
    endfunction

endpackage

// File: rtl/gate_truth_sequencer_if.sv
// Host/gate-side bundle of the gate truth-table sequencer.
//   start, truth_table          : host -> sequencer
//   gate_out                    : gate under test -> sequencer
//   gate_in                     : sequencer -> gate under test
//   busy, done, pass, fail_mask : sequencer -> host
//   err_count, first_err_idx    : sequencer -> host, only with GATE_SEQ_ERR_LOG_EN
interface gate_truth_sequencer_if
    import gate_seq_pkg::*;
#(
    parameter int unsigned N_IN = 2
);
    localparam int unsigned V = v_count(N_IN);

    logic            start;
    logic [V-1:0]    truth_table;
    logic [N_IN-1:0] gate_in;
    logic            gate_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [V-1:0]    fail_mask;
`ifdef GATE_SEQ_ERR_LOG_EN
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_err_idx;

    modport slave (
        input  start, truth_table, gate_out,
        output gate_in, busy, done, pass, fail_mask, err_count, first_err_idx
    );
    modport master (
        output start, truth_table, gate_out,
        input  gate_in, busy, done, pass, fail_mask, err_count, first_err_idx
    );
`else
    modport slave (
        input  start, truth_table, gate_out,
        output gate_in, busy, done, pass, fail_mask
    );
    modport master (
        output start, truth_table, gate_out,
        input  gate_in, busy, done, pass, fail_mask
    );
`endif

endinterface

// File: rtl/gate_seq_settle_timer.sv
// Loadable down-counter with a zero flag, used to hold each vector.
//   clk, rst    : clock, async active-high reset
//   i_load      : load i_load_val (has priority over i_en)
//   i_load_val  : value to load
//   i_en        : decrement by one, stopping at zero
//   o_zero_c    : count is zero (combinational from the count register)
module gate_seq_settle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= W'(0);
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != W'(0))) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == W'(0));

endmodule

// File: rtl/gate_truth_sequencer.sv
// Sweeps a single N-input gate through every input vector, holds each vector
// SETTLE_CYCLES+2 cycles, samples gate_out on the last edge of the window and
// compares it against a truth table captured at start.
//   clk, rst : clock, async active-high reset
//   bus      : gate_truth_sequencer_if.slave (start/truth_table in, gate_in
//              drive, gate_out sample, busy/done/pass/fail_mask results)
// Optional macro GATE_SEQ_ERR_LOG_EN adds err_count and first_err_idx.
module gate_truth_sequencer
    import gate_seq_pkg::*;
#(
    parameter int unsigned N_IN          = 2,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    gate_truth_sequencer_if.slave   bus
);

    localparam int unsigned V  = v_count(N_IN);
    localparam int unsigned EW = N_IN + 1;

    state_t          r_state;
    logic [V-1:0]    r_tt;
    logic [N_IN-1:0] r_idx;
    logic [N_IN-1:0] r_gate_in;
    logic [V-1:0]    r_fail;
    logic            r_pass;
    logic            r_done;
    logic            r_busy;

    state_t          w_state_nxt;
    logic [V-1:0]    w_tt_nxt;
    logic [N_IN-1:0] w_idx_nxt;
    logic [N_IN-1:0] w_gate_in_nxt;
    logic [V-1:0]    w_fail_nxt;
    logic            w_pass_nxt;
    logic            w_done_nxt;
    logic            w_busy_nxt;
    logic            w_tmr_load;
    logic            w_tmr_en;
    logic            w_tmr_zero;
    logic            w_mis;

`ifdef GATE_SEQ_ERR_LOG_EN
    logic [EW-1:0]   r_err_cnt;
    logic [N_IN-1:0] r_first;
    logic [EW-1:0]   w_err_cnt_nxt;
    logic [N_IN-1:0] w_first_nxt;
`endif

    gate_seq_settle_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (CNT_W'(SETTLE_CYCLES)),
        .i_en       (w_tmr_en),
        .o_zero_c   (w_tmr_zero)
    );

    assign w_mis = (bus.gate_out != r_tt[r_idx]);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next register values
    always_comb begin
        w_state_nxt   = r_state;
        w_tt_nxt      = r_tt;
        w_idx_nxt     = r_idx;
        w_gate_in_nxt = r_gate_in;
        w_fail_nxt    = r_fail;
        w_pass_nxt    = r_pass;
        w_done_nxt    = 1'b0;
        w_tmr_load    = 1'b0;
        w_tmr_en      = 1'b0;
`ifdef GATE_SEQ_ERR_LOG_EN
        w_err_cnt_nxt = r_err_cnt;
        w_first_nxt   = r_first;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt   = ST_SETTLE;
                    w_tt_nxt      = bus.truth_table;
                    w_fail_nxt    = V'(0);
                    w_pass_nxt    = 1'b0;
                    w_idx_nxt     = N_IN'(0);
                    w_gate_in_nxt = N_IN'(0);
                    w_tmr_load    = 1'b1;
`ifdef GATE_SEQ_ERR_LOG_EN
                    w_err_cnt_nxt = EW'(0);
                    w_first_nxt   = N_IN'(0);
`endif
                end
            end
            ST_SETTLE: begin
                if (w_tmr_zero) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (w_mis) begin
                    w_fail_nxt = r_fail | (V'(1) << r_idx);
`ifdef GATE_SEQ_ERR_LOG_EN
                    // A zero count means this is the first mismatch of the sweep
                    if (r_err_cnt == EW'(0)) begin
                        w_first_nxt = r_idx;
                    end
                    if (r_err_cnt != EW'(V)) begin
                        w_err_cnt_nxt = r_err_cnt + EW'(1);
                    end
`endif
                end
                if (r_idx == N_IN'(V - 1)) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    // Includes this cycle's compare result
                    w_pass_nxt  = (w_fail_nxt == V'(0));
                end else begin
                    w_state_nxt   = ST_SETTLE;
                    w_idx_nxt     = r_idx + N_IN'(1);
                    w_gate_in_nxt = r_idx + N_IN'(1);
                    w_tmr_load    = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tt      <= V'(0);
            r_idx     <= N_IN'(0);
            r_gate_in <= N_IN'(0);
            r_fail    <= V'(0);
            r_pass    <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_tt      <= w_tt_nxt;
            r_idx     <= w_idx_nxt;
            r_gate_in <= w_gate_in_nxt;
            r_fail    <= w_fail_nxt;
            r_pass    <= w_pass_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign bus.gate_in   = r_gate_in;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.fail_mask = r_fail;

`ifdef GATE_SEQ_ERR_LOG_EN
    // Error log registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= EW'(0);
            r_first   <= N_IN'(0);
        end else begin
            r_err_cnt <= w_err_cnt_nxt;
            r_first   <= w_first_nxt;
        end
    end

    assign bus.err_count     = r_err_cnt;
    assign bus.first_err_idx = r_first;
`endif

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Directed bench for gate_truth_sequencer: two instances (settle 2 and
// settle 0) driving an XNOR gate model, with an optional stuck-at-1 fault
// on vector 2. Error-log outputs are checked when GATE_SEQ_ERR_LOG_EN is set.
module tb_gate_truth_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   mode;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edges;
    int   dones;
    logic [1:0] gi_hist [16];

    always #5 clk = ~clk;

    gate_truth_sequencer_if #(.N_IN(2)) bus0 ();
    gate_truth_sequencer_if #(.N_IN(2)) bus1 ();

    // XNOR, optionally stuck at 1 when gate_in == 2
    function automatic logic gate_model(input logic [1:0] gi, input int m);
        logic x;
        x = ~(gi[0] ^ gi[1]);
        if (m == 1 && gi == 2'd2) x = 1'b1;
        return x;
    endfunction

    assign bus0.gate_out = gate_model(bus0.gate_in, mode);
    assign bus1.gate_out = gate_model(bus1.gate_in, 0);

    gate_truth_sequencer #(.N_IN(2), .SETTLE_CYCLES(2)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    gate_truth_sequencer #(.N_IN(2), .SETTLE_CYCLES(0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on dut0 and return the edges from the start edge to done
    task automatic run_sweep(input logic [3:0] tt, output int n_edges);
        bus0.truth_table = tt;
        bus0.start       = 1'b1;
        tick();
        bus0.start = 1'b0;
        n_edges = 0;
        while (!bus0.done && n_edges < 100) begin
            if (n_edges < 16) gi_hist[n_edges] = bus0.gate_in;
            tick();
            n_edges++;
        end
    endtask

    initial begin
        rst              = 1'b1;
        mode             = 0;
        bus0.start       = 1'b0;
        bus0.truth_table = 4'b0000;
        bus1.start       = 1'b0;
        bus1.truth_table = 4'b0000;
        #1;
        check("rst_gate_in", 32'(bus0.gate_in), 0);
        check("rst_busy", 32'(bus0.busy), 0);
        check("rst_done", 32'(bus0.done), 0);
        check("rst_pass", 32'(bus0.pass), 0);
        check("rst_fail_mask", 32'(bus0.fail_mask), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // XNOR with the correct table
        run_sweep(4'b1001, edges);
        check("xnor_latency", 32'(edges), 16);
        check("xnor_pass", 32'(bus0.pass), 1);
        check("xnor_fail_mask", 32'(bus0.fail_mask), 0);
        check("xnor_busy_in_done", 32'(bus0.busy), 1);
        for (int m = 0; m < 16; m++) begin
            check($sformatf("xnor_gate_in_%0d", m), 32'(gi_hist[m]), 32'(m / 4));
        end
`ifdef GATE_SEQ_ERR_LOG_EN
        check("xnor_err_count", 32'(bus0.err_count), 0);
        check("xnor_first_err", 32'(bus0.first_err_idx), 0);
`endif
        tick();
        check("xnor_done_pulse", 32'(bus0.done), 0);
        check("xnor_busy_after", 32'(bus0.busy), 0);
        check("xnor_pass_held", 32'(bus0.pass), 1);

        // Inverted table: every vector mismatches
        run_sweep(4'b0110, edges);
        check("wrong_latency", 32'(edges), 16);
        check("wrong_fail_mask", 32'(bus0.fail_mask), 32'hf);
        check("wrong_pass", 32'(bus0.pass), 0);
`ifdef GATE_SEQ_ERR_LOG_EN
        check("wrong_err_count", 32'(bus0.err_count), 4);
        check("wrong_first_err", 32'(bus0.first_err_idx), 0);
`endif
        tick();

        // Gate stuck at 1 on vector 2
        mode = 1;
        run_sweep(4'b1001, edges);
        check("fault_latency", 32'(edges), 16);
        check("fault_fail_mask", 32'(bus0.fail_mask), 32'h4);
        check("fault_pass", 32'(bus0.pass), 0);
`ifdef GATE_SEQ_ERR_LOG_EN
        check("fault_err_count", 32'(bus0.err_count), 1);
        check("fault_first_err", 32'(bus0.first_err_idx), 2);
`endif
        mode = 0;
        tick();

        // Second start and zero table at edge 5 must be ignored
        bus0.truth_table = 4'b1001;
        bus0.start       = 1'b1;
        tick();
        bus0.start = 1'b0;
        dones      = 0;
        for (int n = 1; n <= 30; n++) begin
            if (n == 5) begin
                bus0.start       = 1'b1;
                bus0.truth_table = 4'b0000;
            end
            if (n == 6) bus0.start = 1'b0;
            tick();
            if (bus0.done) dones++;
        end
        check("busy_start_dones", 32'(dones), 1);
        check("busy_start_fail_mask", 32'(bus0.fail_mask), 0);
        check("busy_start_pass", 32'(bus0.pass), 1);
        bus0.truth_table = 4'b1001;

        // Reset in the middle of vector 1
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (6) tick();
        check("midrst_gate_in_before", 32'(bus0.gate_in), 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_gate_in", 32'(bus0.gate_in), 0);
        check("midrst_busy", 32'(bus0.busy), 0);
        check("midrst_done", 32'(bus0.done), 0);
        check("midrst_pass", 32'(bus0.pass), 0);
        check("midrst_fail_mask", 32'(bus0.fail_mask), 0);
        dones = 0;
        repeat (3) begin
            tick();
            if (bus0.done) dones++;
        end
        rst = 1'b0;
        repeat (20) begin
            tick();
            if (bus0.done) dones++;
        end
        check("midrst_no_done", 32'(dones), 0);
        run_sweep(4'b1001, edges);
        check("postrst_latency", 32'(edges), 16);
        check("postrst_pass", 32'(bus0.pass), 1);
        check("postrst_fail_mask", 32'(bus0.fail_mask), 0);
        tick();

        // Zero settle time with start held high
        bus1.truth_table = 4'b1001;
        bus1.start       = 1'b1;
        tick();
        edges = 0;
        while (!bus1.done && edges < 100) begin
            tick();
            edges++;
        end
        check("s0_latency", 32'(edges), 8);
        check("s0_pass", 32'(bus1.pass), 1);
        tick();
        check("s0_idle_gap_busy", 32'(bus1.busy), 0);
        check("s0_idle_gap_done", 32'(bus1.done), 0);
        tick();
        check("s0_restart_busy", 32'(bus1.busy), 1);
        edges = 0;
        while (!bus1.done && edges < 100) begin
            tick();
            edges++;
        end
        check("s0_second_latency", 32'(edges), 8);
        check("s0_second_pass", 32'(bus1.pass), 1);
        bus1.start = 1'b0;
        tick();
        tick();
        check("s0_stopped_busy", 32'(bus1.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
